run_ctrl: RTL and testbench
===========================

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; synchronous and active-high.
REQ-003 i_vl  input  1  pixel valid; one pixel per cycle max, no backpressure.
REQ-004 i_sof  input  1  start of scan; qualifies with i_vl.
REQ-005 i_eol  input  1  last pixel of line; qualifies with i_vl.
REQ-006 i_run  input  1  upstream context says run mode (all gradients zero); qualifies with i_vl.
REQ-007 i_x, i_ra, i_rb  input  8 each  current pixel, left and upper neighbours.
REQ-008 o_rg_vl  output  1  pixel routed to regular-mode coder.
REQ-009 o_rl_vl / o_rl_bv[15:0] / o_rl_bc[4:0]  output  run-length token: bc LSBs of bv, MSB first.
REQ-010 o_vl, o_x[7:0], o_px[7:0], o_s, o_q, o_cn[3:0]  output  run-interruption pixel to run-mode pipeline (same meanings as that pipeline's inputs).

Function
REQ-011 All outputs SHALL be registered, latency exactly 1 cycle from the accepted pixel.
REQ-012 States SHALL be REGULAR and RUN; reset and i_sof enter REGULAR.
REQ-013 REGULAR, i_vl & ~i_run: o_rg_vl=1 for that pixel, state unchanged.
REQ-014 REGULAR, i_vl & i_run: latch RUNval=i_ra, cnt=0, evaluate this pixel as first RUN pixel in the same cycle (REQ-015..018).
REQ-015 Run hit (i_x==RUNval): cnt+1==rm (rm=1<<J[RUNindex]) -> emit token bv=1,bc=1, cnt=0, RUNindex=min(RUNindex+1,31); else cnt=cnt+1, no token.
REQ-016 Run hit with i_eol: after REQ-015, if resulting cnt>0 emit bv=1,bc=1 (RUNindex unchanged); cnt=0; go REGULAR; never both tokens -- segment completion suppresses the eol token.
REQ-017 Interruption (i_x!=RUNval), eol or not: emit token bv=cnt, bc=J[RUNindex]+1 (implicit leading 0); o_vl=1 same cycle with o_x=i_x, o_q=(i_ra==i_rb), o_px=o_q?i_ra:i_rb, o_s=~o_q&(i_ra>i_rb), o_cn=J[RUNindex] before decrement; then RUNindex=max(RUNindex-1,0), cnt=0, go REGULAR.
REQ-018 Downstream SHALL treat a same-cycle run-length token as preceding the interruption pixel.
REQ-019 i_vl=0 cycles SHALL hold all state and drive all valids 0.
REQ-020 i_sof with i_vl: clear RUNindex to 0 first, then process the pixel from REGULAR.
REQ-021 cnt SHALL be 16 bits; rk=J[RUNindex] max 15 so cnt<rm always.
REQ-022 While in RUN, i_run SHALL be ignored.

Reset
REQ-023 rst SHALL force state REGULAR, RUNindex=0, cnt=0, RUNval=0, all valids 0, all data outputs 0, overriding any concurrent pixel.
REQ-024 Reset mid-run SHALL discard the partial run without emitting a token.

Configuration
REQ-025 RUN_CTRL_PERF_EN defined: add outputs o_nrun[15:0] (runs started) and o_nint[15:0] (interruptions), wrapping, cleared by rst and i_sof.
REQ-026 RUN_CTRL_PERF_EN undefined: those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-027 Shared package SHALL hold the 32-entry J table, RUNINDEX_MAX=31, token widths (16/5).
REQ-028 Single module; no sub-modules needed.

Verification
REQ-029 i_run=1, RUNval=5, 4 hits from RUNindex 0 -> four tokens (1,1), RUNindex=4.
REQ-030 RUNindex=4 (rk=1), one hit then x=9, ra=3, rb=7 -> token bv=1,bc=2; o_vl, o_q=0, o_px=7, o_s=0, o_cn=1; RUNindex=3.
REQ-031 RUNindex=0, hit with i_eol -> token (1,1), RUNindex=1; next pixel i_run=0 -> o_rg_vl=1.
REQ-032 RUNindex=5 (rk=1), one hit then hit with i_eol -> cnt reaches rm: single token (1,1), RUNindex=6, REGULAR.
REQ-033 First run pixel mismatches, ra=rb=8 -> token bv=0,bc=J[idx]+1; o_q=1, o_px=8; RUNindex=31 saturation and 0 floor checked.
REQ-034 rst asserted mid-run with i_vl=1 -> next cycle all valids 0; after release, run restarts at RUNindex 0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run-mode controller: states, J table, widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package run_ctrl_pkg;

    localparam int PIX_W = 8;
    localparam int IDX_W = 5;
    localparam int RK_W  = 4;
    localparam int CNT_W = 16;
    localparam int BV_W  = 16;
    localparam int BC_W  = 5;

    localparam logic [IDX_W-1:0] RUNINDEX_MAX = 5'd31;

    typedef enum logic {
        ST_REGULAR = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    // Run-length order for each RUNindex; a run segment completes after
    // 1 << J[RUNindex] matching pixels.
    localparam logic [RK_W-1:0] J_TABLE [0:31] = '{
        4'd0,  4'd0,  4'd0,  4'd0,  4'd1,  4'd1,  4'd1,  4'd1,
        4'd2,  4'd2,  4'd2,  4'd2,  4'd3,  4'd3,  4'd3,  4'd3,
        4'd4,  4'd4,  4'd5,  4'd5,  4'd6,  4'd6,  4'd7,  4'd7,
        4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    function automatic logic [RK_W-1:0] rk_of(input logic [IDX_W-1:0] idx);
        return J_TABLE[idx];
    endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Pixel-in / token-and-pixel-out bundle of the run-mode controller.
// Latency: n/a (wiring only); outputs are registered inside run_ctrl.
// Backpressure: none; i_vl is a one-pixel-per-cycle strobe.
// Ports: i_vl/i_sof/i_eol/i_run/i_x/i_ra/i_rb in; o_rg_vl, run-length token
// (o_rl_vl/o_rl_bv/o_rl_bc) and interruption pixel (o_vl/o_x/o_px/o_s/o_q/o_cn) out.
interface run_ctrl_if;
    import run_ctrl_pkg::*;

    logic             i_vl;
    logic             i_sof;
    logic             i_eol;
    logic             i_run;
    logic [PIX_W-1:0] i_x;
    logic [PIX_W-1:0] i_ra;
    logic [PIX_W-1:0] i_rb;

    logic             o_rg_vl;
    logic             o_rl_vl;
    logic [BV_W-1:0]  o_rl_bv;
    logic [BC_W-1:0]  o_rl_bc;
    logic             o_vl;
    logic [PIX_W-1:0] o_x;
    logic [PIX_W-1:0] o_px;
    logic             o_s;
    logic             o_q;
    logic [RK_W-1:0]  o_cn;

    modport master (
        output i_vl, i_sof, i_eol, i_run, i_x, i_ra, i_rb,
        input  o_rg_vl, o_rl_vl, o_rl_bv, o_rl_bc,
        input  o_vl, o_x, o_px, o_s, o_q, o_cn
    );

    modport slave (
        input  i_vl, i_sof, i_eol, i_run, i_x, i_ra, i_rb,
        output o_rg_vl, o_rl_vl, o_rl_bv, o_rl_bc,
        output o_vl, o_x, o_px, o_s, o_q, o_cn
    );

endinterface

// File: rtl/run_ctrl.sv
// Run-mode controller: routes pixels to the regular coder or accumulates runs,
// emitting run-length tokens and run-interruption pixels.
// Latency: 1 cycle, all outputs registered. Backpressure: none (i_vl strobe).
// Ports: clk, rst (sync, active-high), bus (run_ctrl_if.slave).
// Optional RUN_CTRL_PERF_EN adds o_nrun/o_nint wrapping event counters.
module run_ctrl
    import run_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    run_ctrl_if.slave    bus
`ifdef RUN_CTRL_PERF_EN
    ,
    output logic [15:0]  o_nrun,
    output logic [15:0]  o_nint
`endif
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PIX_W-1:0]  rv_q, rv_d;

    logic              rg_vl_q, rg_vl_d;
    logic              rl_vl_q, rl_vl_d;
    logic [BV_W-1:0]   rl_bv_q, rl_bv_d;
    logic [BC_W-1:0]   rl_bc_q, rl_bc_d;
    logic              vl_q, vl_d;
    logic [PIX_W-1:0]  x_q, x_d;
    logic [PIX_W-1:0]  px_q, px_d;
    logic              s_q, s_d;
    logic              q_q, q_d;
    logic [RK_W-1:0]   cn_q, cn_d;

    // Effective state after applying start-of-scan, which resets the run
    // context before the pixel itself is evaluated.
    state_t            cur_state;
    logic [IDX_W-1:0]  cur_idx;
    logic [CNT_W-1:0]  cur_cnt;
    logic [PIX_W-1:0]  cur_rv;
    logic              run_eval;
    logic [RK_W-1:0]   rk;
    logic [CNT_W-1:0]  rm;
    logic [CNT_W-1:0]  cnt_inc;
    logic              nb_eq;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rv_d     = rv_q;
        rg_vl_d  = 1'b0;
        rl_vl_d  = 1'b0;
        rl_bv_d  = rl_bv_q;
        rl_bc_d  = rl_bc_q;
        vl_d     = 1'b0;
        x_d      = x_q;
        px_d     = px_q;
        s_d      = s_q;
        q_d      = q_q;
        cn_d     = cn_q;

        cur_state = bus.i_sof ? ST_REGULAR : state_q;
        cur_idx   = bus.i_sof ? '0 : idx_q;
        cur_cnt   = bus.i_sof ? '0 : cnt_q;
        cur_rv    = rv_q;
        run_eval  = 1'b0;
        rk        = rk_of(cur_idx);
        rm        = {{(CNT_W-1){1'b0}}, 1'b1} << rk;
        cnt_inc   = '0;
        nb_eq     = (bus.i_ra == bus.i_rb);

        if (bus.i_vl) begin
            state_d = cur_state;
            idx_d   = cur_idx;
            cnt_d   = cur_cnt;

            case (cur_state)
                ST_REGULAR: begin
                    if (bus.i_run) begin
                        // Run starts on this pixel: it is also the first
                        // pixel compared against the freshly latched value.
                        run_eval = 1'b1;
                        cur_rv   = bus.i_ra;
                        cur_cnt  = '0;
                        rv_d     = bus.i_ra;
                    end else begin
                        rg_vl_d = 1'b1;
                    end
                end
                // i_run is deliberately ignored once a run is open.
                ST_RUN: run_eval = 1'b1;
                default: run_eval = 1'b0;
            endcase

            if (run_eval) begin
                cnt_inc = cur_cnt + 1'b1;
                if (bus.i_x == cur_rv) begin
                    if (cnt_inc == rm) begin
                        rl_vl_d = 1'b1;
                        rl_bv_d = BV_W'(1);
                        rl_bc_d = BC_W'(1);
                        cnt_d   = '0;
                        idx_d   = (cur_idx == RUNINDEX_MAX) ? cur_idx : cur_idx + 1'b1;
                    end else begin
                        cnt_d   = cnt_inc;
                    end

                    if (bus.i_eol) begin
                        // A partial segment at end of line is flagged with a
                        // single '1'; a just-completed segment already left
                        // cnt at zero, so at most one token is emitted.
                        if (cnt_d != '0) begin
                            rl_vl_d = 1'b1;
                            rl_bv_d = BV_W'(1);
                            rl_bc_d = BC_W'(1);
                        end
                        cnt_d   = '0;
                        state_d = ST_REGULAR;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    // Interruption: residual count in rk bits behind a '0'.
                    rl_vl_d = 1'b1;
                    rl_bv_d = cur_cnt;
                    rl_bc_d = {1'b0, rk} + 1'b1;
                    vl_d    = 1'b1;
                    x_d     = bus.i_x;
                    q_d     = nb_eq;
                    px_d    = nb_eq ? bus.i_ra : bus.i_rb;
                    s_d     = ~nb_eq & (bus.i_ra > bus.i_rb);
                    cn_d    = rk;
                    idx_d   = (cur_idx == '0) ? cur_idx : cur_idx - 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REGULAR;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REGULAR;
            idx_q   <= '0;
            cnt_q   <= '0;
            rv_q    <= '0;
            rg_vl_q <= 1'b0;
            rl_vl_q <= 1'b0;
            rl_bv_q <= '0;
            rl_bc_q <= '0;
            vl_q    <= 1'b0;
            x_q     <= '0;
            px_q    <= '0;
            s_q     <= 1'b0;
            q_q     <= 1'b0;
            cn_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            rg_vl_q <= rg_vl_d;
            rl_vl_q <= rl_vl_d;
            rl_bv_q <= rl_bv_d;
            rl_bc_q <= rl_bc_d;
            vl_q    <= vl_d;
            x_q     <= x_d;
            px_q    <= px_d;
            s_q     <= s_d;
            q_q     <= q_d;
            cn_q    <= cn_d;
        end
    end

    assign bus.o_rg_vl = rg_vl_q;
    assign bus.o_rl_vl = rl_vl_q;
    assign bus.o_rl_bv = rl_bv_q;
    assign bus.o_rl_bc = rl_bc_q;
    assign bus.o_vl    = vl_q;
    assign bus.o_x     = x_q;
    assign bus.o_px    = px_q;
    assign bus.o_s     = s_q;
    assign bus.o_q     = q_q;
    assign bus.o_cn    = cn_q;

`ifdef RUN_CTRL_PERF_EN
    // Start-of-scan clears the counters, then the pixel carrying it is counted.
    logic        run_start;
    logic        perf_clr;
    logic [15:0] nrun_q;
    logic [15:0] nint_q;

    assign run_start = bus.i_vl & bus.i_run & (bus.i_sof | (state_q == ST_REGULAR));
    assign perf_clr  = bus.i_vl & bus.i_sof;

    always_ff @(posedge clk) begin
        if (rst) begin
            nrun_q <= '0;
            nint_q <= '0;
        end else begin
            nrun_q <= (perf_clr ? 16'd0 : nrun_q) + {15'd0, run_start};
            nint_q <= (perf_clr ? 16'd0 : nint_q) + {15'd0, vl_d};
        end
    end

    assign o_nrun = nrun_q;
    assign o_nint = nint_q;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus random pixels,
// expected outputs from a behavioural model pushed into a scoreboard queue
// and popped by a monitor whenever the DUT presents a valid.
module tb_run_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    run_ctrl_if bus();

`ifdef RUN_CTRL_PERF_EN
    logic [15:0] nrun;
    logic [15:0] nint;
`endif

    run_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef RUN_CTRL_PERF_EN
        ,
        .o_nrun (nrun),
        .o_nint (nint)
`endif
    );

    typedef struct {
        int cyc;
        bit rg;
        bit rl;
        bit vl;
        int bv;
        int bc;
        int x;
        int px;
        int s;
        int q;
        int cn;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    int jt [0:31] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,
                      4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15};

    // Reference model state: in_run flag, run index, run count, run value.
    bit m_run = 1'b0;
    int m_idx = 0;
    int m_cnt = 0;
    int m_rv  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_idx = 0;
        m_cnt = 0;
        m_rv  = 0;
    endtask

    // Applies the coding rules to one accepted pixel and queues whatever the
    // DUT must show one cycle later.
    task automatic model_pix(input bit sof, input bit eol, input bit run,
                             input int x, input int ra, input int rb);
        exp_t e;
        int   rm;
        e = '{cyc: cyc + 1, rg: 0, rl: 0, vl: 0, bv: 0, bc: 0,
               x: 0, px: 0, s: 0, q: 0, cn: 0};
        if (sof) model_reset();
        if (!m_run && !run) begin
            e.rg = 1'b1;
        end else begin
            if (!m_run) begin
                m_rv  = ra;
                m_cnt = 0;
            end
            rm = 1 << jt[m_idx];
            if (x == m_rv) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == rm) begin
                    e.rl = 1'b1; e.bv = 1; e.bc = 1;
                    m_cnt = 0;
                    if (m_idx < 31) m_idx = m_idx + 1;
                end
                if (eol) begin
                    if (m_cnt > 0) begin
                        e.rl = 1'b1; e.bv = 1; e.bc = 1;
                    end
                    m_cnt = 0;
                    m_run = 1'b0;
                end else begin
                    m_run = 1'b1;
                end
            end else begin
                e.rl = 1'b1;
                e.bv = m_cnt;
                e.bc = jt[m_idx] + 1;
                e.vl = 1'b1;
                e.x  = x;
                e.q  = (ra == rb) ? 1 : 0;
                e.px = (ra == rb) ? ra : rb;
                e.s  = (ra != rb && ra > rb) ? 1 : 0;
                e.cn = jt[m_idx];
                if (m_idx > 0) m_idx = m_idx - 1;
                m_cnt = 0;
                m_run = 1'b0;
            end
        end
        if (e.rg || e.rl || e.vl) sbq.push_back(e);
    endtask

    task automatic drive(input bit vl, input bit sof, input bit eol, input bit run,
                         input int x, input int ra, input int rb);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus.i_vl   = vl;
        bus.i_sof  = sof;
        bus.i_eol  = eol;
        bus.i_run  = run;
        bus.i_x    = x[7:0];
        bus.i_ra   = ra[7:0];
        bus.i_rb   = rb[7:0];
        if (vl) model_pix(sof, eol, run, x, ra, rb);
    endtask

    task automatic pix(input bit sof, input bit eol, input bit run,
                       input int x, input int ra, input int rb);
        drive(1'b1, sof, eol, run, x, ra, rb);
    endtask

    task automatic do_reset(input bit vl);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.i_vl  = vl;
        bus.i_sof = 1'b0;
        bus.i_eol = 1'b0;
        bus.i_run = 1'b1;
        bus.i_x   = 8'($urandom_range(0, 3));
        bus.i_ra  = 8'($urandom_range(0, 3));
        bus.i_rb  = 8'($urandom_range(0, 3));
        model_reset();
    endtask

    // Monitor: pops one expectation for every cycle the DUT shows a valid.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && (bus.o_rg_vl || bus.o_rl_vl || bus.o_vl)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("out_cycle", cyc, e.cyc);
                chk("rg_vl", int'(bus.o_rg_vl), int'(e.rg));
                chk("rl_vl", int'(bus.o_rl_vl), int'(e.rl));
                chk("pix_vl", int'(bus.o_vl), int'(e.vl));
                if (e.rl) begin
                    chk("rl_bv", int'(bus.o_rl_bv), e.bv);
                    chk("rl_bc", int'(bus.o_rl_bc), e.bc);
                end
                if (e.vl) begin
                    chk("o_x", int'(bus.o_x), e.x);
                    chk("o_px", int'(bus.o_px), e.px);
                    chk("o_s", int'(bus.o_s), e.s);
                    chk("o_q", int'(bus.o_q), e.q);
                    chk("o_cn", int'(bus.o_cn), e.cn);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        bus.i_vl  = 1'b1;
        bus.i_sof = 1'b0;
        bus.i_eol = 1'b0;
        bus.i_run = 1'b1;
        bus.i_x   = 8'd0;
        bus.i_ra  = 8'd0;
        bus.i_rb  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valids", int'({bus.o_rg_vl, bus.o_rl_vl, bus.o_vl}), 0);
        chk("reset_token", int'({bus.o_rl_bv, bus.o_rl_bc}), 0);
        chk("reset_pixel", int'({bus.o_x, bus.o_px, bus.o_s, bus.o_q, bus.o_cn}), 0);
        mon_en = 1'b1;

        // Four single-pixel segments from index 0, then index 4 (rk=1):
        // one hit and an interruption with ra<rb.
        pix(1, 0, 1, 5, 5, 5);
        pix(0, 0, 0, 5, 5, 5);
        pix(0, 0, 1, 5, 0, 0);
        pix(0, 0, 0, 5, 5, 5);
        pix(0, 0, 1, 5, 0, 0);
        pix(0, 0, 0, 9, 3, 7);

        // Hit with end-of-line at index 0, then a regular pixel.
        pix(1, 1, 1, 5, 5, 1);
        pix(0, 0, 0, 7, 1, 2);

        // Climb to index 5, then hit + hit-with-eol completing the segment.
        pix(1, 0, 1, 5, 5, 5);
        repeat (5) pix(0, 0, 0, 5, 5, 5);
        pix(0, 0, 0, 5, 5, 5);
        pix(0, 1, 0, 5, 5, 5);
        pix(0, 0, 0, 4, 1, 1);

        // First run pixel mismatches with ra==rb; index floor at 0.
        pix(1, 0, 1, 3, 8, 8);
        pix(0, 0, 1, 8, 8, 2);
        pix(0, 0, 0, 9, 2, 1);

        // Idle cycles inside a run hold the partial count.
        pix(1, 0, 1, 6, 6, 6);
        pix(0, 0, 0, 6, 6, 6);
        pix(0, 0, 0, 6, 6, 6);
        pix(0, 0, 0, 6, 6, 6);
        pix(0, 0, 0, 6, 6, 6);
        drive(0, 1, 1, 0, 7, 1, 1);
        drive(0, 0, 0, 0, 6, 6, 6);
        pix(0, 0, 0, 6, 6, 6);
        pix(0, 0, 0, 2, 9, 9);

        // Reset mid-run with a concurrent pixel: no outputs, run restarts.
        pix(1, 0, 1, 4, 4, 4);
        pix(0, 0, 0, 4, 4, 4);
        pix(0, 0, 0, 4, 4, 4);
        pix(0, 0, 0, 4, 4, 4);
        pix(0, 0, 0, 4, 4, 4);
        do_reset(1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("midrun_reset_valids", int'({bus.o_rg_vl, bus.o_rl_vl, bus.o_vl}), 0);
        pix(0, 0, 1, 4, 4, 4);
        pix(0, 0, 0, 1, 4, 4);

        // Long run: climb to index 31, complete one 32768-pixel segment there
        // (index must saturate), then interrupt after 100 more hits.
        pix(1, 0, 1, 5, 5, 5);
        for (int i = 0; i < 65919; i++) pix(0, 0, 1'($urandom_range(0, 1)), 5, 5, 5);
        pix(0, 0, 0, 6, 1, 2);
        pix(0, 0, 1, 3, 3, 3);
        pix(0, 0, 0, 4, 3, 3);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            int r;
            int ra;
            int rb;
            int x;
            bit vl;
            bit sof;
            bit eol;
            bit run;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                vl  = (r < 85);
                sof = ($urandom_range(0, 99) < 4);
                eol = ($urandom_range(0, 99) < 12);
                run = ($urandom_range(0, 99) < 45);
                ra  = $urandom_range(0, 3);
                rb  = $urandom_range(0, 3);
                if (m_run && !sof)
                    x = ($urandom_range(0, 3) != 0) ? m_rv : $urandom_range(0, 3);
                else
                    x = ($urandom_range(0, 3) != 0) ? ra : $urandom_range(0, 255);
                drive(vl, sof, eol, run, x, ra, rb);
            end
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("leftover_expected", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
